bp_fpga_host_uart_nbf_assembler: RTL and testbench

// Host-side receive stage between uart_rx and the FPGA host NBF command path.

---
 rtl/bp_fpga_host_pkg.sv | 13 +
 rtl/bsg_counter_clear_up.sv | 15 +
 rtl/bp_fpga_host_uart_nbf_assembler.sv | 88 ++++++++
 tb/tb_bp_fpga_host_uart_nbf_assembler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bp_fpga_host_pkg.sv
// bp_fpga_host_pkg: shared NBF packet layout, width helper and assembler state enum
package bp_fpga_host_pkg;
  localparam int nbf_opcode_width_gp = 8;
  typedef enum logic {e_idle, e_collect} bp_fpga_host_asm_state_e;
  typedef struct packed {
    logic [63:0] data;
    logic [39:0] addr;
    logic [7:0]  opcode;
  } bp_fpga_host_nbf_s;
  function automatic int bp_fpga_host_nbf_width(int addr_width, int data_width);
    return nbf_opcode_width_gp + addr_width + data_width;
  endfunction
endpackage

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up: up counter with synchronous clear and asynchronous active-low reset
module bsg_counter_clear_up #(
  parameter int max_val_p = 255,
  localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_active_low_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);
  always_ff @(posedge clk_i or negedge reset_active_low_i)
    if (!reset_active_low_i) count_o <= '0;
    else count_o <= (clear_i ? '0 : count_o) + ptr_width_lp'(up_i);
endmodule

// File: rtl/bp_fpga_host_uart_nbf_assembler.sv
// bp_fpga_host_uart_nbf_assembler: packs UART bytes LSB-first into NBF packets behind a one-deep output register
module bp_fpga_host_uart_nbf_assembler
  import bp_fpga_host_pkg::*;
#(
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int timeout_cycles_p = 100000,
  localparam int nbf_width_lp = bp_fpga_host_nbf_width(nbf_addr_width_p, nbf_data_width_p),
  localparam int nbf_bytes_lp = nbf_width_lp / 8
) (
  input  logic                    clk_i,
  input  logic                    reset_active_low_i,
  input  logic                    rx_v_i,
  input  logic [7:0]              rx_i,
  input  logic                    rx_error_i,
  output logic [nbf_width_lp-1:0] nbf_o,
  output logic                    nbf_v_o,
  input  logic                    nbf_ready_and_i,
  output logic                    frame_error_o,
  output logic                    timeout_o,
  output logic                    overflow_o
);
  localparam int cnt_width_lp = $clog2(nbf_bytes_lp + 1);
  localparam int tmr_width_lp = $clog2(timeout_cycles_p + 1);

  if (nbf_width_lp % 8 != 0) begin : g_width_check
    $error("nbf_width_lp must be a multiple of 8");
  end

  bp_fpga_host_asm_state_e state_r, state_n;
  logic [cnt_width_lp-1:0] count_r, count_n;
  logic [nbf_width_lp-1:0] asm_r, asm_n;
  logic [tmr_width_lp-1:0] idle_cnt;
  logic accept, err, last, fire, drop, load, tmr_clear;

  assign accept    = rx_v_i & ~rx_error_i;
  assign err       = rx_v_i & rx_error_i;
  assign last      = accept & (count_r == cnt_width_lp'(nbf_bytes_lp - 1));
  assign fire      = (state_r == e_collect) & ~rx_v_i & (idle_cnt == tmr_width_lp'(timeout_cycles_p - 1));
  assign drop      = err | fire | last;
  // a completing packet loads only if the output slot is empty or being drained this cycle
  assign load      = last & (~nbf_v_o | nbf_ready_and_i);
  assign tmr_clear = (state_r == e_idle) | rx_v_i | fire;

  bsg_counter_clear_up #(.max_val_p(timeout_cycles_p)) timer (
    .clk_i(clk_i),
    .reset_active_low_i(reset_active_low_i),
    .clear_i(tmr_clear),
    .up_i(~tmr_clear),
    .count_o(idle_cnt)
  );

  always_comb begin
    state_n = drop ? e_idle : accept ? e_collect : state_r;
    count_n = drop ? '0 : count_r + cnt_width_lp'(accept);
    asm_n   = asm_r;
    for (int k = 0; k < nbf_bytes_lp; k++)
      if (accept && count_r == cnt_width_lp'(k)) asm_n[8*k+:8] = rx_i;
  end

  always_ff @(posedge clk_i or negedge reset_active_low_i)
    if (!reset_active_low_i) begin
      state_r <= e_idle;
      count_r <= '0;
      asm_r   <= '0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      asm_r   <= asm_n;
    end

  always_ff @(posedge clk_i or negedge reset_active_low_i)
    if (!reset_active_low_i) begin
      nbf_o         <= '0;
      nbf_v_o       <= 1'b0;
      frame_error_o <= 1'b0;
      timeout_o     <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      frame_error_o <= err;
      timeout_o     <= fire;
      nbf_v_o       <= load | (nbf_v_o & ~nbf_ready_and_i);
      if (load) nbf_o <= asm_n;
      if (last & ~load) overflow_o <= 1'b1;
    end

  assert property (@(posedge clk_i) disable iff (!reset_active_low_i) rx_v_i |-> !$isunknown(rx_i));
endmodule

// File: tb/tb_bp_fpga_host_uart_nbf_assembler.sv
// tb_bp_fpga_host_uart_nbf_assembler: vector table, corner sequences and random traffic against a byte-queue model
module tb_bp_fpga_host_uart_nbf_assembler;
  localparam int T = 100, NB = 14, W = 112;
  logic clk = 0, rst_n = 1, rx_v = 0, rx_err = 0, ready = 0;
  logic [7:0] rx_b = 0;
  logic [W-1:0] nbf;
  logic nbf_v, fe, to, ovf;
  always #5 clk = ~clk;

  bp_fpga_host_uart_nbf_assembler #(.timeout_cycles_p(T)) dut (
    .clk_i(clk), .reset_active_low_i(rst_n), .rx_v_i(rx_v), .rx_i(rx_b), .rx_error_i(rx_err),
    .nbf_o(nbf), .nbf_v_o(nbf_v), .nbf_ready_and_i(ready),
    .frame_error_o(fe), .timeout_o(to), .overflow_o(ovf)
  );

  int tests = 0, fails = 0, n_fe = 0, n_to = 0;
  logic [7:0] q[$];
  int ic;
  logic m_v, m_fe, m_to, m_ovf;
  logic [W-1:0] m_o;

  typedef struct {
    logic [7:0]  op;
    logic [39:0] addr;
    logic [63:0] data;
    int junk, mode, split_gap, exp_fe, exp_to;
  } vec_t;
  vec_t vecs[5];

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset;
    q.delete(); ic = 0; m_v = 0; m_fe = 0; m_to = 0; m_ovf = 0; m_o = '0;
  endtask

  // packet-level reference: bytes queue up, 14 of them form a packet, the output slot holds one
  task automatic model_step;
    logic hs, loaded;
    logic [W-1:0] pkt;
    hs = m_v & ready; loaded = 0; m_fe = 0; m_to = 0;
    if (rx_v && rx_err) begin
      q.delete(); ic = 0; m_fe = 1;
    end else if (rx_v) begin
      q.push_back(rx_b); ic = 0;
      if (q.size() == NB) begin
        for (int k = 0; k < NB; k++) pkt[8*k+:8] = q[k];
        q.delete();
        if (!m_v || ready) begin m_o = pkt; loaded = 1; end
        else m_ovf = 1;
      end
    end else if (q.size() > 0) begin
      ic++;
      if (ic == T) begin q.delete(); ic = 0; m_to = 1; end
    end
    if (loaded) m_v = 1;
    else if (hs) m_v = 0;
  endtask

  task automatic step;
    @(posedge clk);
    model_step();
    #1;
    check("nbf_v", W'(nbf_v), W'(m_v));
    if (m_v) check("nbf_o", nbf, m_o);
    check("frame_error", W'(fe), W'(m_fe));
    check("timeout", W'(to), W'(m_to));
    check("overflow", W'(ovf), W'(m_ovf));
    n_fe += int'(fe); n_to += int'(to);
  endtask

  task automatic idle(int n);
    rx_v = 0;
    repeat (n) step();
  endtask

  task automatic send(logic [7:0] b, logic e);
    rx_v = 1; rx_b = b; rx_err = e;
    step();
    rx_v = 0; rx_err = 0;
  endtask

  task automatic send_pkt(logic [W-1:0] p, int from, int upto, int gap, int split_gap);
    for (int k = from; k < upto; k++) begin
      send(p[8*k+:8], 1'b0);
      if (k < upto - 1) idle(k == 2 ? split_gap : gap);
    end
  endtask

  task automatic do_reset;
    #2 rst_n = 0;
    #1;
    check("rst_nbf_o", nbf, '0);
    check("rst_nbf_v", W'(nbf_v), '0);
    check("rst_frame_error", W'(fe), '0);
    check("rst_timeout", W'(to), '0);
    check("rst_overflow", W'(ovf), '0);
    model_reset();
    @(negedge clk) rst_n = 1;
  endtask

  initial begin
    logic [W-1:0] p, pa, pb;
    vecs[0] = '{8'h03, 40'h00_8000_0000, 64'h0000_0000_0000_00AB, 0, 0, 9, 0, 0};
    vecs[1] = '{8'h13, 40'h00_8000_0000, 64'h0, 5, 1, 9, 1, 0};
    vecs[2] = '{8'h03, 40'h12_3456_789A, 64'hDEAD_BEEF_0123_4567, 3, 2, 9, 0, 1};
    vecs[3] = '{8'h03, 40'hFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 99, 0, 0};
    vecs[4] = '{8'h13, 40'h00_0000_0001, 64'h5555_AAAA_5555_AAAA, 0, 1, 9, 1, 0};
    do_reset();

    ready = 1;
    foreach (vecs[i]) begin
      p = {vecs[i].data, vecs[i].addr, vecs[i].op};
      n_fe = 0; n_to = 0;
      for (int j = 0; j < vecs[i].junk; j++) begin
        send(8'($urandom), 1'b0);
        idle(2);
      end
      if (vecs[i].mode == 1) begin send(8'($urandom), 1'b1); idle(3); end
      if (vecs[i].mode == 2) idle(T - 2 + 3);
      send_pkt(p, 0, NB, 9, vecs[i].split_gap);
      check("vec_nbf_v_rise", W'(nbf_v), W'(1));
      check("vec_nbf_o", nbf, p);
      step();
      check("vec_nbf_v_drop", W'(nbf_v), '0);
      check("vec_frame_pulses", W'(n_fe), W'(vecs[i].exp_fe));
      check("vec_timeout_pulses", W'(n_to), W'(vecs[i].exp_to));
    end

    ready = 0;
    pa = {64'h1111_2222_3333_4444, 40'h00_8000_0040, 8'h03};
    pb = {64'h9999_8888_7777_6666, 40'h00_8000_0080, 8'h03};
    send_pkt(pa, 0, NB, 2, 2);
    send_pkt(pb, 0, NB, 2, 2);
    idle(50);
    check("ovf_sticky", W'(ovf), W'(1));
    check("ovf_keeps_first", nbf, pa);
    ready = 1;
    step();
    ready = 0;
    check("ovf_accept_drop", W'(nbf_v), '0);
    idle(20);
    check("ovf_no_second", W'(nbf_v), '0);

    send_pkt(pb, 0, NB, 1, 1);
    idle(2);
    check("v_before_reset", W'(nbf_v), W'(1));
    do_reset();

    send_pkt(pa, 0, NB, 1, 1);
    send_pkt(pb, 0, NB - 1, 1, 1);
    idle(1);
    ready = 1;
    send(pb[8*(NB-1)+:8], 1'b0);
    check("sim_v_stays", W'(nbf_v), W'(1));
    check("sim_reload", nbf, pb);
    check("sim_no_ovf", W'(ovf), '0);
    step();

    send_pkt(pa, 0, 7, 3, 3);
    do_reset();
    ready = 1;
    send_pkt(pb, 0, NB, 3, 3);
    check("post_reset_pkt", nbf, pb);
    check("post_reset_v", W'(nbf_v), W'(1));
    step();

    for (int i = 0; i < 2000; i++) begin
      int r;
      ready = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 99);
      if (r < 40) send(8'($urandom), r < 2);
      else if (r < 42) idle(T - 1 + $urandom_range(0, 1));
      else idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
